uart_bus_bridge: RTL and testbench

- Byte-level command parser that sits between the UART receiver/transmitter byte streams and the 8-bit memory bus that feeds the text/font memory.
- Lets a host PC write, read and dump video/character memory over the serial link while the display runs.
- Drives the same master-side bus signals the memory consumes: address, write data, cs, we; read data and ack are returned.
- Pure protocol and sequencing; serialisation lives in the existing UART.

---
 rtl/bridge_pkg.sv | 27 ++
 rtl/bridge_timeout.sv | 28 ++
 rtl/uart_bus_bridge.sv | 172 +++++++++++++++++
 tb/tb_uart_bus_bridge.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// Shared constants and state encoding for the UART-to-memory-bus command bridge.
package bridge_pkg;

  localparam logic [7:0] CMD_W   = 8'h57;
  localparam logic [7:0] CMD_R   = 8'h52;
  localparam logic [7:0] CMD_D   = 8'h44;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h3F;

  localparam int unsigned DUMP_CNT_W = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD_AH,
    ST_CMD_AL,
    ST_GET_DATA,
    ST_BUS,
    ST_WAIT_RD,
    ST_TX
  } state_e;

  // A dump length byte of zero stands for 256 bytes.
  function automatic logic [DUMP_CNT_W-1:0] dump_len(input logic [7:0] n);
    return (n == 8'd0) ? DUMP_CNT_W'(256) : DUMP_CNT_W'(n);
  endfunction

endpackage

// File: rtl/bridge_timeout.sv
// Inter-byte idle counter: cleared on each received byte, held at zero while
// not running, and strobes expiry after TIMEOUT_CYCLES-1 idle cycles.
module bridge_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 2500000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_run,
  input  logic i_clear,
  output logic o_expire_c
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q;

  // A byte arriving in the expiry cycle wins over the timeout.
  assign o_expire_c = i_run && !i_clear && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear || !i_run) begin
      cnt_q <= '0;
    end else if (!o_expire_c) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_bus_bridge.sv
// Serial command parser: turns W/R/D byte commands from the UART into single
// memory bus cycles and streams the replies back to the UART transmitter.
module uart_bus_bridge
  import bridge_pkg::*;
#(
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned TIMEOUT_CYCLES = 2500000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [7:0]        i_rx_dat,
  input  logic              i_rx_valid,
  output logic [7:0]        o_tx_dat,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic [ADDR_W-1:0] o_addr,
  output logic [7:0]        o_dat,
  input  logic [7:0]        i_dat,
  output logic              o_cs,
  output logic              o_we,
  input  logic              i_ack
);

  localparam int unsigned LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  state_e                  state_q;
  logic [7:0]              cmd_q;
  logic [7:0]              ah_q;
  logic [DUMP_CNT_W-1:0]   cnt_q;
  logic [LAT_W-1:0]        lat_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [7:0]              dat_q;
  logic                    cs_q;
  logic                    we_q;
  logic [7:0]              tx_dat_q;
  logic                    tx_valid_q;
  logic                    run_c;
  logic                    expire_c;

  assign o_addr     = addr_q;
  assign o_dat      = dat_q;
  assign o_cs       = cs_q;
  assign o_we       = we_q;
  assign o_tx_dat   = tx_dat_q;
  assign o_tx_valid = tx_valid_q;

  assign run_c = (state_q == ST_CMD_AH) || (state_q == ST_CMD_AL) || (state_q == ST_GET_DATA);

  bridge_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_run     (run_c),
    .i_clear   (i_rx_valid),
    .o_expire_c(expire_c)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      cmd_q      <= '0;
      ah_q       <= '0;
      cnt_q      <= '0;
      lat_q      <= '0;
      addr_q     <= '0;
      dat_q      <= '0;
      cs_q       <= 1'b0;
      we_q       <= 1'b0;
      tx_dat_q   <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_rx_valid) begin
            cmd_q <= i_rx_dat;
            if (i_rx_dat == CMD_W || i_rx_dat == CMD_R || i_rx_dat == CMD_D) begin
              state_q <= ST_CMD_AH;
            end else begin
              cnt_q      <= '0;
              tx_dat_q   <= RSP_ERR;
              tx_valid_q <= 1'b1;
              state_q    <= ST_TX;
            end
          end
        end
        ST_CMD_AH: begin
          if (i_rx_valid) begin
            ah_q    <= i_rx_dat;
            state_q <= ST_CMD_AL;
          end else if (expire_c) begin
            state_q <= ST_IDLE;
          end
        end
        ST_CMD_AL: begin
          if (i_rx_valid) begin
            addr_q <= ADDR_W'({ah_q, i_rx_dat});
            if (cmd_q == CMD_R) begin
              we_q    <= 1'b0;
              cnt_q   <= DUMP_CNT_W'(1);
              cs_q    <= 1'b1;
              state_q <= ST_BUS;
            end else begin
              state_q <= ST_GET_DATA;
            end
          end else if (expire_c) begin
            state_q <= ST_IDLE;
          end
        end
        ST_GET_DATA: begin
          if (i_rx_valid) begin
            cs_q    <= 1'b1;
            state_q <= ST_BUS;
            if (cmd_q == CMD_W) begin
              we_q  <= 1'b1;
              dat_q <= i_rx_dat;
              cnt_q <= DUMP_CNT_W'(1);
            end else begin
              we_q  <= 1'b0;
              cnt_q <= dump_len(i_rx_dat);
            end
          end else if (expire_c) begin
            state_q <= ST_IDLE;
          end
        end
        ST_BUS: begin
          if (i_ack) begin
            cs_q <= 1'b0;
            if (we_q) begin
              tx_dat_q   <= RSP_OK;
              tx_valid_q <= 1'b1;
              state_q    <= ST_TX;
            end else if (READ_LATENCY == 0) begin
              tx_dat_q   <= i_dat;
              tx_valid_q <= 1'b1;
              state_q    <= ST_TX;
            end else begin
              lat_q   <= LAT_W'(READ_LATENCY - 1);
              state_q <= ST_WAIT_RD;
            end
          end
        end
        ST_WAIT_RD: begin
          if (lat_q == '0) begin
            tx_dat_q   <= i_dat;
            tx_valid_q <= 1'b1;
            state_q    <= ST_TX;
          end else begin
            lat_q <= lat_q - LAT_W'(1);
          end
        end
        ST_TX: begin
          // The next dump read waits until the previous byte is taken.
          if (i_tx_ready) begin
            tx_valid_q <= 1'b0;
            if (cnt_q > DUMP_CNT_W'(1)) begin
              cnt_q   <= cnt_q - DUMP_CNT_W'(1);
              addr_q  <= addr_q + ADDR_W'(1);
              cs_q    <= 1'b1;
              state_q <= ST_BUS;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Directed bench for uart_bus_bridge: memory slave with stall control, UART
// transmit sink with throttling, and hand-computed expected replies.
module tb_uart_bus_bridge;

  logic        clk        = 1'b0;
  logic        i_reset    = 1'b1;
  logic [7:0]  i_rx_dat   = 8'h00;
  logic        i_rx_valid = 1'b0;
  logic [7:0]  o_tx_dat;
  logic        o_tx_valid;
  logic        i_tx_ready = 1'b1;
  logic [15:0] o_addr;
  logic [7:0]  o_dat;
  logic [7:0]  i_dat      = 8'hEE;
  logic        o_cs;
  logic        o_we;
  logic        i_ack      = 1'b0;

  uart_bus_bridge #(
    .ADDR_W        (16),
    .READ_LATENCY  (1),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .i_clk     (clk),
    .i_reset   (i_reset),
    .i_rx_dat  (i_rx_dat),
    .i_rx_valid(i_rx_valid),
    .o_tx_dat  (o_tx_dat),
    .o_tx_valid(o_tx_valid),
    .i_tx_ready(i_tx_ready),
    .o_addr    (o_addr),
    .o_dat     (o_dat),
    .i_dat     (i_dat),
    .o_cs      (o_cs),
    .o_we      (o_we),
    .i_ack     (i_ack)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  mem     [0:65535];
  bit          wr_flag [0:65535];
  logic [7:0]  tx_log  [0:1023];
  logic [15:0] bus_log [0:1023];
  int tx_cnt = 0, bus_cnt = 0, wr_cnt = 0, cs_cyc = 0;
  int bus_viol = 0, tx_viol = 0, outst_viol = 0;
  logic [15:0] last_waddr = '0;
  logic [7:0]  last_wdat  = '0;
  int stall = 0;
  bit slow_ready = 1'b0;
  int rd_ptr = 0;

  logic        prev_cs = 1'b0, prev_tv = 1'b0, p_we = 1'b0;
  logic [15:0] p_addr = '0;
  logic [7:0]  p_dat = '0, p_td = '0;
  bit          rd_pend = 1'b0;
  logic [15:0] rd_addr = '0;
  int          wcnt = 0, cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Unwritten locations read back as a fixed function of the address.
  function automatic logic [7:0] rdval(input logic [15:0] a);
    return wr_flag[a] ? mem[a] : (a[7:0] ^ a[15:8]);
  endfunction

  // Bus slave and transmit sink: observe at negedge, drive just after posedge.
  initial begin : slave
    forever begin
      @(negedge clk);
      if (prev_cs && (!o_cs || o_addr != p_addr || o_dat != p_dat || o_we != p_we)) bus_viol++;
      if (o_cs) cs_cyc++;
      if (o_cs && i_ack) begin
        if (bus_cnt < 1024) bus_log[bus_cnt] = o_addr;
        bus_cnt++;
        if (o_we) begin
          mem[o_addr] = o_dat;
          wr_flag[o_addr] = 1'b1;
          wr_cnt++;
          last_waddr = o_addr;
          last_wdat = o_dat;
        end else begin
          rd_pend = 1'b1;
          rd_addr = o_addr;
        end
      end
      prev_cs = o_cs && !i_ack;
      p_addr = o_addr;
      p_dat = o_dat;
      p_we = o_we;
      if (prev_tv && (!o_tx_valid || o_tx_dat != p_td)) tx_viol++;
      if (o_tx_valid && o_cs) outst_viol++;
      if (o_tx_valid && i_tx_ready) begin
        if (tx_cnt < 1024) tx_log[tx_cnt] = o_tx_dat;
        tx_cnt++;
      end
      prev_tv = o_tx_valid && !i_tx_ready;
      p_td = o_tx_dat;
      @(posedge clk);
      #1;
      i_dat = rd_pend ? rdval(rd_addr) : 8'hEE;
      rd_pend = 1'b0;
      if (!o_cs) begin
        i_ack = 1'b0;
        wcnt = 0;
      end else if (wcnt >= stall) begin
        i_ack = 1'b1;
      end else begin
        i_ack = 1'b0;
        wcnt++;
      end
      cyc++;
      i_tx_ready = slow_ready ? (cyc % 7 == 0) : 1'b1;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_dat = b;
    i_rx_valid = 1'b1;
    @(posedge clk);
    #1;
    i_rx_valid = 1'b0;
  endtask

  task automatic wr_cmd(input logic [7:0] ah, input logic [7:0] al, input logic [7:0] d);
    send_byte(8'h57);
    send_byte(ah);
    send_byte(al);
    send_byte(d);
  endtask

  task automatic rd_cmd(input logic [7:0] ah, input logic [7:0] al);
    send_byte(8'h52);
    send_byte(ah);
    send_byte(al);
  endtask

  task automatic expect_reply(input string tag, input logic [7:0] exp);
    int n;
    n = 0;
    while (rd_ptr >= tx_cnt && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (rd_ptr < tx_cnt) begin
      check(tag, 32'(tx_log[rd_ptr]), 32'(exp));
      rd_ptr++;
    end else begin
      check({tag, "_no_reply"}, 32'hFFFF_FFFF, 32'(exp));
    end
  endtask

  initial begin : main
    int b0, t0, w0, c0, n;

    tick(3);
    check("rst_cs", 32'(o_cs), 32'd0);
    check("rst_we", 32'(o_we), 32'd0);
    check("rst_tx_valid", 32'(o_tx_valid), 32'd0);
    check("rst_addr", 32'(o_addr), 32'd0);
    check("rst_dat", 32'(o_dat), 32'd0);
    check("rst_tx_dat", 32'(o_tx_dat), 32'd0);
    i_reset = 1'b0;
    tick(2);

    // Write against a slave that stalls for five cycles.
    stall = 5;
    c0 = cs_cyc;
    w0 = wr_cnt;
    wr_cmd(8'h12, 8'h34, 8'hA5);
    expect_reply("wr_reply", 8'h4B);
    check("wr_count", wr_cnt - w0, 1);
    check("wr_addr", 32'(last_waddr), 32'h1234);
    check("wr_data", 32'(last_wdat), 32'hA5);
    check("wr_cs_cycles", cs_cyc - c0, 6);
    check("wr_bus_stable", bus_viol, 0);
    stall = 0;
    tick(2);

    rd_cmd(8'h12, 8'h34);
    expect_reply("rd_reply", 8'hA5);
    tick(2);

    // Dump across the top of the address space.
    wr_cmd(8'hFF, 8'hFE, 8'h11);
    expect_reply("wr_fffe", 8'h4B);
    wr_cmd(8'hFF, 8'hFF, 8'h22);
    expect_reply("wr_ffff", 8'h4B);
    wr_cmd(8'h00, 8'h00, 8'h33);
    expect_reply("wr_0000", 8'h4B);
    b0 = bus_cnt;
    send_byte(8'h44);
    send_byte(8'hFF);
    send_byte(8'hFE);
    send_byte(8'h03);
    expect_reply("dump3_b0", 8'h11);
    expect_reply("dump3_b1", 8'h22);
    expect_reply("dump3_b2", 8'h33);
    tick(10);
    check("dump3_cycles", bus_cnt - b0, 3);
    check("dump3_addr0", 32'(bus_log[b0]), 32'hFFFE);
    check("dump3_addr1", 32'(bus_log[b0 + 1]), 32'hFFFF);
    check("dump3_addr2", 32'(bus_log[b0 + 2]), 32'h0000);

    // Unknown command byte.
    b0 = bus_cnt;
    c0 = cs_cyc;
    send_byte(8'h41);
    expect_reply("unk_reply", 8'h3F);
    tick(5);
    check("unk_no_cs", cs_cyc - c0, 0);
    rd_cmd(8'h12, 8'h34);
    expect_reply("unk_then_rd", 8'hA5);
    tick(2);

    // Abort after 100 idle cycles; next bytes parse as a fresh read.
    w0 = wr_cnt;
    send_byte(8'h57);
    send_byte(8'h00);
    tick(100);
    b0 = bus_cnt;
    rd_cmd(8'h00, 8'h10);
    expect_reply("to_read_reply", 8'h10);
    check("to_no_write", wr_cnt - w0, 0);
    check("to_read_cycles", bus_cnt - b0, 1);
    check("to_read_addr", 32'(bus_log[b0]), 32'h0010);
    tick(2);

    // A byte landing in the expiry cycle keeps the command alive.
    send_byte(8'h57);
    send_byte(8'h00);
    tick(99);
    send_byte(8'h20);
    send_byte(8'h5A);
    expect_reply("to_edge_reply", 8'h4B);
    check("to_edge_writes", wr_cnt - w0, 1);
    check("to_edge_addr", 32'(last_waddr), 32'h0020);
    check("to_edge_data", 32'(last_wdat), 32'h5A);
    tick(2);

    // 256-byte dump with a transmitter ready one cycle in seven.
    slow_ready = 1'b1;
    t0 = tx_cnt;
    b0 = bus_cnt;
    send_byte(8'h44);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h00);
    for (int k = 0; k < 256; k++) begin
      expect_reply("dump256_byte", 8'(k) ^ 8'h01);
    end
    slow_ready = 1'b0;
    tick(50);
    check("dump256_count", tx_cnt - t0, 256);
    check("dump256_cycles", bus_cnt - b0, 256);
    check("dump256_tx_stable", tx_viol, 0);
    check("dump256_outstanding", outst_viol, 0);

    // Reset while waiting for read data.
    b0 = bus_cnt;
    t0 = tx_cnt;
    rd_cmd(8'h12, 8'h34);
    n = 0;
    while (bus_cnt == b0 && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("rstrd_accepted", bus_cnt - b0, 1);
    i_reset = 1'b1;
    @(posedge clk);
    #2;
    check("rstrd_cs", 32'(o_cs), 32'd0);
    check("rstrd_we", 32'(o_we), 32'd0);
    check("rstrd_tx_valid", 32'(o_tx_valid), 32'd0);
    check("rstrd_addr", 32'(o_addr), 32'd0);
    check("rstrd_dat", 32'(o_dat), 32'd0);
    check("rstrd_tx_dat", 32'(o_tx_dat), 32'd0);
    @(posedge clk);
    #2;
    i_reset = 1'b0;
    tick(20);
    check("rstrd_no_reply", tx_cnt - t0, 0);
    rd_cmd(8'h12, 8'h34);
    expect_reply("rstrd_then_rd", 8'hA5);
    tick(5);

    check("bus_stable_all", bus_viol, 0);
    check("tx_stable_all", tx_viol, 0);
    check("outstanding_all", outst_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
